// File: rtl/m_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// mux selects, fault causes and the decoded-opcode / control-strobe bundles.
package m_multicycle_ctrl_pkg;

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_REL   = 2'b01,
    PC_JALR  = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    FAULT_NONE = 2'b00,
    FAULT_ILL  = 2'b01,
    FAULT_MEM  = 2'b10
  } fault_e;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_jal;
    logic is_jalr;
    logic is_u;
    logic is_sys;
    logic illegal;
  } dec_t;

  // Every datapath strobe driven by the FSM; cleared as one unit in reset/halt.
  typedef struct packed {
    logic    mem_re;
    logic    mem_we;
    logic    mem_isel;
    logic    ir_we;
    logic    pc_we;
    pc_sel_e pc_sel;
    logic    alu_src;
    logic    rf_we;
    wb_sel_e wb_sel;
    logic    retire;
  } ctrl_t;

  function automatic logic uses_mem(input dec_t d);
    return d.is_ld | d.is_st;
  endfunction

  function automatic wb_sel_e wb_select(input dec_t d);
    if (d.is_ld)               return WB_MEM;
    if (d.is_jal | d.is_jalr)  return WB_PC4;
    return WB_ALU;
  endfunction

  function automatic pc_sel_e wb_pc_select(input dec_t d);
    if (d.is_jal)  return PC_REL;
    if (d.is_jalr) return PC_JALR;
    return PC_PLUS4;
  endfunction

endpackage

// File: rtl/m_multicycle_ctrl_if.sv
// Shared memory port between the control FSM (master) and the memory (slave).
interface m_multicycle_ctrl_if;

  logic w_mem_re;
  logic w_mem_we;
  logic w_mem_isel;
  logic w_mem_ready;

  modport master (
    output w_mem_re,
    output w_mem_we,
    output w_mem_isel,
    input  w_mem_ready
  );

  modport slave (
    input  w_mem_re,
    input  w_mem_we,
    input  w_mem_isel,
    output w_mem_ready
  );

endinterface

// File: rtl/m_multicycle_ctrl_decode.sv
// Opcode classifier: turns IR[6:0] into one-hot instruction-class flags.
module m_ctrl_decode
  import m_multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output dec_t       dec_o
);

  // NOTE: dec_o is cleared before the case so every opcode path drives all
  // flags and no latch is inferred.
  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_R:             dec_o.is_r    = 1'b1;
      OP_I:             dec_o.is_i    = 1'b1;
      OP_LD:            dec_o.is_ld   = 1'b1;
      OP_ST:            dec_o.is_st   = 1'b1;
      OP_BR:            dec_o.is_br   = 1'b1;
      OP_JAL:           dec_o.is_jal  = 1'b1;
      OP_JALR:          dec_o.is_jalr = 1'b1;
      OP_LUI, OP_AUIPC: dec_o.is_u    = 1'b1;
      OP_SYS:           dec_o.is_sys  = 1'b1;
      default:          dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one ready-handshaked memory port, counts retired instructions, halts on faults.
module m_multicycle_ctrl
  import m_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter bit          HALT_ILL = 1'b1
) (
  input  logic                       w_clk,
  input  logic                       w_rst,
  input  logic [6:0]                 w_opcode,
  input  logic                       w_br_taken,
  m_multicycle_ctrl_if.master        mem_bus,
  output logic                       w_ir_we,
  output logic                       w_pc_we,
  output logic [1:0]                 w_pc_sel,
  output logic                       w_alu_src,
  output logic                       w_rf_we,
  output logic [1:0]                 w_wb_sel,
  output logic                       w_retire,
  output logic [31:0]                w_instret,
  output logic [2:0]                 w_state,
  output logic                       w_halted,
  output logic [1:0]                 w_fault
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         instret_q, instret_d;
  logic                halted_q, halted_d;
  fault_e              fault_q, fault_d;
  dec_t                dec;
  ctrl_t               ctl;
  logic                mem_ready;
  logic                mem_timeout;

  m_ctrl_decode u_decode (
    .opcode_i (w_opcode),
    .dec_o    (dec)
  );

  assign mem_ready   = mem_bus.w_mem_ready;
  assign mem_timeout = (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    ctl     = '0;

    case (state_q)
      S_IF: begin
        ctl.mem_re   = 1'b1;
        ctl.mem_isel = 1'b1;
        if (mem_ready) begin
          ctl.ir_we = 1'b1;
          state_d   = S_ID;
        end else if (mem_timeout) begin
          state_d = S_HALT;
          fault_d = FAULT_MEM;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_ID: begin
        if (dec.is_sys) begin
          state_d = S_HALT;
        end else if (dec.illegal) begin
          if (HALT_ILL) begin
            state_d = S_HALT;
            fault_d = FAULT_ILL;
          end else begin
            ctl.pc_we  = 1'b1;
            ctl.retire = 1'b1;
            state_d    = S_IF;
          end
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        ctl.alu_src = ~(dec.is_r | dec.is_br);
        if (dec.is_br) begin
          ctl.pc_we  = 1'b1;
          ctl.pc_sel = w_br_taken ? PC_REL : PC_PLUS4;
          ctl.retire = 1'b1;
          state_d    = S_IF;
        end else if (uses_mem(dec)) begin
          state_d = S_MEM;
        end else if (dec.is_r | dec.is_i | dec.is_u | dec.is_jal | dec.is_jalr) begin
          state_d = S_WB;
        end else begin
          // Opcode changed after S_ID screened it; stop rather than guess.
          state_d = S_HALT;
          fault_d = FAULT_ILL;
        end
      end

      S_MEM: begin
        ctl.mem_re = dec.is_ld;
        ctl.mem_we = dec.is_st;
        if (mem_ready) begin
          if (dec.is_ld) begin
            state_d = S_WB;
          end else begin
            ctl.pc_we  = 1'b1;
            ctl.retire = 1'b1;
            state_d    = S_IF;
          end
        end else if (mem_timeout) begin
          state_d = S_HALT;
          fault_d = FAULT_MEM;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_WB: begin
        ctl.rf_we  = 1'b1;
        ctl.pc_we  = 1'b1;
        ctl.retire = 1'b1;
        ctl.wb_sel = wb_select(dec);
        ctl.pc_sel = wb_pc_select(dec);
        state_d    = S_IF;
      end

      S_HALT: ;

      default: state_d = S_HALT;
    endcase

    // Any state change starts a fresh wait window for the next access.
    if (state_d != state_q) begin
      wait_d = '0;
    end

    if (w_rst) begin
      ctl = '0;
    end
  end

  assign halted_d  = halted_q | (state_d == S_HALT);
  assign instret_d = ctl.retire ? instret_q + 32'd1 : instret_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= FAULT_NONE;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign mem_bus.w_mem_re   = ctl.mem_re;
  assign mem_bus.w_mem_we   = ctl.mem_we;
  assign mem_bus.w_mem_isel = ctl.mem_isel;
  assign w_ir_we            = ctl.ir_we;
  assign w_pc_we            = ctl.pc_we;
  assign w_pc_sel           = ctl.pc_sel;
  assign w_alu_src          = ctl.alu_src;
  assign w_rf_we            = ctl.rf_we;
  assign w_wb_sel           = ctl.wb_sel;
  assign w_retire           = ctl.retire;
  assign w_instret          = instret_q;
  assign w_state            = state_q;
  assign w_halted           = halted_q;
  assign w_fault            = fault_q;

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Directed self-checking bench for m_multicycle_ctrl (WAIT_MAX=15, HALT_ILL=1).
module tb_m_multicycle_ctrl;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  // Field order: re we isel ir_we pc_we pc_sel[2] alu_src rf_we wb_sel[2] retire
  localparam logic [11:0] SV_NONE    = 12'b0_0_0_0_0_00_0_0_00_0;
  localparam logic [11:0] SV_IF_RDY  = 12'b1_0_1_1_0_00_0_0_00_0;
  localparam logic [11:0] SV_IF_WAIT = 12'b1_0_1_0_0_00_0_0_00_0;
  localparam logic [11:0] SV_EX_IMM  = 12'b0_0_0_0_0_00_1_0_00_0;
  localparam logic [11:0] SV_EX_BR_T = 12'b0_0_0_0_1_01_0_0_00_1;
  localparam logic [11:0] SV_EX_BR_N = 12'b0_0_0_0_1_00_0_0_00_1;
  localparam logic [11:0] SV_MEM_LD  = 12'b1_0_0_0_0_00_0_0_00_0;
  localparam logic [11:0] SV_MEM_STW = 12'b0_1_0_0_0_00_0_0_00_0;
  localparam logic [11:0] SV_MEM_STR = 12'b0_1_0_0_1_00_0_0_00_1;
  localparam logic [11:0] SV_WB_ALU  = 12'b0_0_0_0_1_00_0_1_00_1;
  localparam logic [11:0] SV_WB_LD   = 12'b0_0_0_0_1_00_0_1_01_1;
  localparam logic [11:0] SV_WB_JAL  = 12'b0_0_0_0_1_01_0_1_10_1;
  localparam logic [11:0] SV_WB_JALR = 12'b0_0_0_0_1_10_0_1_10_1;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        ir_we, pc_we, alu_src, rf_we, retire, halted;
  logic [1:0]  pc_sel, wb_sel, fault;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [11:0] strobes;

  int checks = 0;
  int errors = 0;
  int rf_cnt = 0;

  m_multicycle_ctrl_if mem_if ();

  m_multicycle_ctrl #(.WAIT_MAX(15), .HALT_ILL(1'b1)) dut (
    .w_clk      (clk),
    .w_rst      (rst),
    .w_opcode   (opcode),
    .w_br_taken (br_taken),
    .mem_bus    (mem_if),
    .w_ir_we    (ir_we),
    .w_pc_we    (pc_we),
    .w_pc_sel   (pc_sel),
    .w_alu_src  (alu_src),
    .w_rf_we    (rf_we),
    .w_wb_sel   (wb_sel),
    .w_retire   (retire),
    .w_instret  (instret),
    .w_state    (state),
    .w_halted   (halted),
    .w_fault    (fault)
  );

  assign strobes = {mem_if.w_mem_re, mem_if.w_mem_we, mem_if.w_mem_isel, ir_we, pc_we,
                    pc_sel, alu_src, rf_we, wb_sel, retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set; samples this cycle, then advances.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] sv);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_strb"}, 32'(strobes), 32'(sv));
    if (rf_we === 1'b1) rf_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag);
    cyc({tag, "_if"}, ST_IF, SV_IF_RDY);
    cyc({tag, "_id"}, ST_ID, SV_NONE);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_strb"}, 32'(strobes), 32'(SV_NONE));
    @(posedge clk);
    #1;
    check({tag, "_rst_state"}, 32'(state), 32'(ST_IF));
    check({tag, "_rst_instret"}, instret, 32'd0);
    check({tag, "_rst_fault"}, 32'(fault), 32'd0);
    check({tag, "_rst_halted"}, 32'(halted), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 7'b0;
    br_taken = 1'b0;
    mem_if.w_mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(ST_IF));
    check("reset_instret", instret, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_strb", 32'(strobes), 32'(SV_NONE));

    // Two back-to-back addi, zero-wait: retire at cycles 4 and 8.
    rst = 1'b0;
    mem_if.w_mem_ready = 1'b1;
    opcode = OPC_I;
    fetch_decode("t1a");
    cyc("t1a_ex", ST_EX, SV_EX_IMM);
    cyc("t1a_wb", ST_WB, SV_WB_ALU);
    check("t1a_instret", instret, 32'd1);
    fetch_decode("t1b");
    cyc("t1b_ex", ST_EX, SV_EX_IMM);
    cyc("t1b_wb", ST_WB, SV_WB_ALU);
    check("t1_instret", instret, 32'd2);
    check("t1_rf_pulses", 32'(rf_cnt), 32'd2);

    // lw with two not-ready cycles in S_MEM: retire at cycle 7.
    opcode = OPC_LD;
    fetch_decode("t2");
    mem_if.w_mem_ready = 1'b0;
    cyc("t2_ex", ST_EX, SV_EX_IMM);
    cyc("t2_mem0", ST_MEM, SV_MEM_LD);
    cyc("t2_mem1", ST_MEM, SV_MEM_LD);
    mem_if.w_mem_ready = 1'b1;
    cyc("t2_mem2", ST_MEM, SV_MEM_LD);
    cyc("t2_wb", ST_WB, SV_WB_LD);
    check("t2_instret", instret, 32'd3);

    // beq taken then not taken: retire in S_EX, no register write.
    opcode = OPC_BR;
    br_taken = 1'b1;
    fetch_decode("t3t");
    cyc("t3t_ex", ST_EX, SV_EX_BR_T);
    check("t3t_instret", instret, 32'd4);
    br_taken = 1'b0;
    fetch_decode("t3n");
    cyc("t3n_ex", ST_EX, SV_EX_BR_N);
    check("t3_instret", instret, 32'd5);
    check("t3_rf_pulses", 32'(rf_cnt), 32'd3);

    // Remaining instruction classes, zero-wait.
    opcode = OPC_R;
    fetch_decode("tr");
    cyc("tr_ex", ST_EX, SV_NONE);
    cyc("tr_wb", ST_WB, SV_WB_ALU);
    opcode = OPC_ST;
    fetch_decode("ts");
    cyc("ts_ex", ST_EX, SV_EX_IMM);
    cyc("ts_mem", ST_MEM, SV_MEM_STR);
    opcode = OPC_JAL;
    fetch_decode("tj");
    cyc("tj_ex", ST_EX, SV_EX_IMM);
    cyc("tj_wb", ST_WB, SV_WB_JAL);
    opcode = OPC_JALR;
    fetch_decode("tjr");
    cyc("tjr_ex", ST_EX, SV_EX_IMM);
    cyc("tjr_wb", ST_WB, SV_WB_JALR);
    opcode = OPC_LUI;
    fetch_decode("tu");
    cyc("tu_ex", ST_EX, SV_EX_IMM);
    cyc("tu_wb", ST_WB, SV_WB_ALU);
    check("tx_instret", instret, 32'd10);
    check("tx_rf_pulses", 32'(rf_cnt), 32'd7);

    // sw interrupted by reset in S_MEM: access dropped, nothing retires.
    opcode = OPC_ST;
    fetch_decode("t6");
    mem_if.w_mem_ready = 1'b0;
    cyc("t6_ex", ST_EX, SV_EX_IMM);
    cyc("t6_mem", ST_MEM, SV_MEM_STW);
    mem_if.w_mem_ready = 1'b1;
    reset_pulse("t6");
    opcode = 7'b0000000;
    #1;
    check("t6_instret_after", instret, 32'd0);
    cyc("t6_if", ST_IF, SV_IF_RDY);

    // Illegal opcode 0000000 halts after S_ID with fault=01.
    cyc("t4_id", ST_ID, SV_NONE);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_fault", 32'(fault), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_if.w_mem_ready = i[0];
      br_taken = i[1];
      cyc("t4_halt", ST_HALT, SV_NONE);
    end
    check("t4_instret", instret, 32'd0);
    reset_pulse("t4");

    // Memory never ready in S_IF: fault=10 after WAIT_MAX+1 cycles.
    opcode = OPC_I;
    mem_if.w_mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc("t5a_wait", ST_IF, SV_IF_WAIT);
    end
    check("t5a_state", 32'(state), 32'(ST_HALT));
    check("t5a_fault", 32'(fault), 32'd2);
    check("t5a_halted", 32'(halted), 32'd1);
    reset_pulse("t5a");

    // Ready arriving exactly at the limit completes the fetch.
    mem_if.w_mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc("t5b_wait", ST_IF, SV_IF_WAIT);
    end
    mem_if.w_mem_ready = 1'b1;
    cyc("t5b_edge", ST_IF, SV_IF_RDY);
    check("t5b_state", 32'(state), 32'(ST_ID));
    check("t5b_fault", 32'(fault), 32'd0);
    check("t5b_halted", 32'(halted), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
